// File: rtl/request_encoder_pkg.sv
// Shared types and constants for the clocked 8-to-3 request encoder.
package request_encoder_pkg;
  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;
endpackage

// File: rtl/request_encoder_prio_enc8.sv
// Combinational 8-input priority encoder: index of the highest set bit plus an any flag.
module prio_enc8
  import request_encoder_pkg::*;
(
  input  logic [N_REQ-1:0]  i_vec,
  output logic [CODE_W-1:0] o_idx,
  output logic              o_any
);
  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (i_vec[i]) o_idx = CODE_W'(i);
  end

  assign o_any = |i_vec;
endmodule

// File: rtl/request_encoder.sv
// Latches active-low requests into a pending set and offers the highest-priority
// index over a valid/ready handshake, clearing the served bit on transfer.
module request_encoder
  import request_encoder_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_bar,
  input  logic              EI_bar,
  input  logic [N_REQ-1:0]  in_bar,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  input  logic              ready,
  output logic              GS_bar,
  output logic              EO_bar
);
  logic [N_REQ-1:0]  r_pending;
  logic [CODE_W-1:0] r_code;
  state_t            r_state;

  logic [N_REQ-1:0]  w_set;
  logic [N_REQ-1:0]  w_clr;
  logic [N_REQ-1:0]  w_pending_nxt;
  logic [CODE_W-1:0] w_top_idx;
  logic              w_any;
  logic              w_xfer;
  state_t            w_state_nxt;
  logic [CODE_W-1:0] w_code_nxt;

  prio_enc8 u_prio (
    .i_vec (r_pending),
    .o_idx (w_top_idx),
    .o_any (w_any)
  );

  assign w_xfer = (r_state == OFFER) && ready;
  assign w_set  = EI_bar ? '0 : ~in_bar;
  assign w_clr  = w_xfer ? (N_REQ'(1) << r_code) : '0;
  // Set is applied after clear so a new request on the served bit survives.
  assign w_pending_nxt = (r_pending & ~w_clr) | w_set;

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = OFFER;
          w_code_nxt  = w_top_idx;
        end
      end
      OFFER: begin
        if (ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_bar) begin
      r_pending <= '0;
      r_state   <= IDLE;
      r_code    <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_state   <= w_state_nxt;
      r_code    <= w_code_nxt;
    end
  end

  assign code   = r_code;
  assign valid  = (r_state == OFFER);
  assign GS_bar = (r_pending == '0);
  assign EO_bar = !(!EI_bar && (r_pending == '0));
endmodule

// File: tb/tb_request_encoder.sv
// Directed, table-driven check of request_encoder plus a hand-written merge sequence.
module tb_request_encoder;
  logic       CLK = 1'b0;
  logic       RST_bar;
  logic       EI_bar;
  logic [7:0] in_bar;
  logic [2:0] code;
  logic       valid;
  logic       ready;
  logic       GS_bar;
  logic       EO_bar;

  int n_cmp = 0;
  int n_bad = 0;

  request_encoder dut (
    .CLK     (CLK),
    .RST_bar (RST_bar),
    .EI_bar  (EI_bar),
    .in_bar  (in_bar),
    .code    (code),
    .valid   (valid),
    .ready   (ready),
    .GS_bar  (GS_bar),
    .EO_bar  (EO_bar)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       ei;
    logic [7:0] inb;
    logic       rdy;
    logic [2:0] e_code;
    logic       e_valid;
    logic       e_gs;
    logic       e_eo;
  } vec_t;

  vec_t tbl[64];
  int   n_vec = 0;

  task automatic add(input logic rst, input logic ei, input logic [7:0] inb, input logic rdy,
                     input logic [2:0] c, input logic v, input logic gs, input logic eo);
    tbl[n_vec] = '{rst, ei, inb, rdy, c, v, gs, eo};
    n_vec++;
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic ei, input logic [7:0] inb, input logic rdy);
    RST_bar = rst; EI_bar = ei; in_bar = inb; ready = rdy;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    RST_bar = 1'b0; EI_bar = 1'b0; in_bar = 8'h00; ready = 1'b0;

    // reset, then idle with nothing captured
    add(0,0,8'h00,0, 3'd0,0,1,0);
    add(0,0,8'h00,0, 3'd0,0,1,0);
    add(1,0,8'hFF,0, 3'd0,0,1,0);
    add(1,0,8'hFF,0, 3'd0,0,1,0);
    // single request on bit 3, ready already high
    add(1,0,8'hF7,1, 3'd0,0,0,1);
    add(1,0,8'hFF,1, 3'd3,1,0,1);
    add(1,0,8'hFF,1, 3'd3,0,1,0);
    add(1,0,8'hFF,0, 3'd3,0,1,0);
    // bits 5 and 0, then bit 7 arrives during the offer of 5
    add(1,0,8'hDE,0, 3'd3,0,0,1);
    add(1,0,8'hFF,0, 3'd5,1,0,1);
    add(1,0,8'h7F,0, 3'd5,1,0,1);
    add(1,0,8'hFF,0, 3'd5,1,0,1);
    add(1,0,8'hFF,1, 3'd5,0,0,1);
    add(1,0,8'hFF,1, 3'd7,1,0,1);
    add(1,0,8'hFF,1, 3'd7,0,0,1);
    add(1,0,8'hFF,1, 3'd0,1,0,1);
    add(1,0,8'hFF,1, 3'd0,0,1,0);
    // set wins over clear on bit 2
    add(1,0,8'hFB,0, 3'd0,0,0,1);
    add(1,0,8'hFF,0, 3'd2,1,0,1);
    add(1,0,8'hFB,1, 3'd2,0,0,1);
    add(1,0,8'hFF,0, 3'd2,1,0,1);
    add(1,0,8'hFF,1, 3'd2,0,1,0);
    // enable gating
    add(1,1,8'h00,0, 3'd2,0,1,1);
    add(1,1,8'h00,0, 3'd2,0,1,1);
    add(1,0,8'hBF,0, 3'd2,0,0,1);
    add(1,1,8'h00,0, 3'd6,1,0,1);
    add(1,1,8'h00,1, 3'd6,0,1,1);
    add(1,0,8'h00,1, 3'd6,0,0,1);
    for (int c = 7; c >= 0; c--) begin
      add(1,0,8'hFF,1, 3'(c),1,0,1);
      if (c == 0) add(1,0,8'hFF,1, 3'd0,0,1,0);
      else        add(1,0,8'hFF,1, 3'(c),0,0,1);
    end
    // reset during an offer with all requests pending
    add(1,0,8'h00,0, 3'd0,0,0,1);
    add(1,0,8'hFF,0, 3'd7,1,0,1);
    add(0,0,8'hFF,1, 3'd0,0,1,0);
    add(1,0,8'hFF,0, 3'd0,0,1,0);
    add(1,0,8'hFF,0, 3'd0,0,1,0);

    @(negedge CLK);
    for (int i = 0; i < n_vec; i++) begin
      step(tbl[i].rst, tbl[i].ei, tbl[i].inb, tbl[i].rdy);
      check("code",   i, {5'd0, code},   {5'd0, tbl[i].e_code});
      check("valid",  i, {7'd0, valid},  {7'd0, tbl[i].e_valid});
      check("GS_bar", i, {7'd0, GS_bar}, {7'd0, tbl[i].e_gs});
      check("EO_bar", i, {7'd0, EO_bar}, {7'd0, tbl[i].e_eo});
    end

    // duplicate request on bit 4 merges: one transfer empties pending
    step(1, 0, 8'hEF, 0);
    check("merge_gs", 100, {7'd0, GS_bar}, 8'd0);
    step(1, 0, 8'hEF, 0);
    check("merge_valid", 101, {7'd0, valid}, 8'd1);
    check("merge_code",  101, {5'd0, code},  8'd4);
    step(1, 0, 8'hFF, 1);
    check("merge_clr_gs", 102, {7'd0, GS_bar}, 8'd1);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 8'hFF, 1);
      check("merge_no_reoffer", 103 + k, {7'd0, valid}, 8'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
